// File: rtl/mlc_weight_loader.sv
`default_nettype none
// ============================================================================
// mlc_weight_loader : row-major MLC weight programming sequencer with settle gap
// Optional feature macro: MLC_LOADER_CHECKSUM_EN (adds checksum output)
// Rev 1.0
// ============================================================================
module mlc_weight_loader #(
  parameter int ROWS             = 32,
  parameter int COLS             = 10,
  parameter int WEIGHT_PRECISION = 4,
  parameter int PROG_GAP         = 2,
  parameter int ROW_AW           = 5,
  parameter int COL_AW           = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WEIGHT_PRECISION-1:0] s_data,
  output logic                        prog_en,
  output logic [ROW_AW-1:0]           addr_row,
  output logic [COL_AW-1:0]           addr_col,
  output logic [WEIGHT_PRECISION-1:0] weight_val,
  output logic                        busy,
  output logic                        done,
`ifdef MLC_LOADER_CHECKSUM_EN
  output logic [15:0]                 checksum,
`endif
  output logic [15:0]                 cells_written
);

  localparam int              GAP_W     = (PROG_GAP > 1) ? $clog2(PROG_GAP) : 1;
  localparam bit              c_HAS_GAP = (PROG_GAP > 0);
  localparam logic [GAP_W-1:0] c_GAP_LAST = (PROG_GAP > 0) ? GAP_W'(PROG_GAP - 1) : '0;
  localparam logic [ROW_AW-1:0] c_ROW_LAST = ROW_AW'(ROWS - 1);
  localparam logic [COL_AW-1:0] c_COL_LAST = COL_AW'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [ROW_AW-1:0]           r_addr_row;
  logic [COL_AW-1:0]           r_addr_col;
  logic [WEIGHT_PRECISION-1:0] r_weight;
  logic [15:0]                 r_cells;
  logic [GAP_W-1:0]            r_gap_cnt;

  logic w_start_ok;
  logic w_hs;
  logic w_last_cell;
  logic w_decide;

  assign w_start_ok  = (r_state == S_IDLE) && start && !abort;
  assign w_hs        = (r_state == S_ACCEPT) && s_valid && !abort;
  assign w_last_cell = (r_addr_row == c_ROW_LAST) && (r_addr_col == c_COL_LAST);
  // Post-write decision point: end of WRITE when there is no gap, else last GAP cycle.
  assign w_decide    = !abort &&
                       (((r_state == S_WRITE) && !c_HAS_GAP) ||
                        ((r_state == S_GAP) && (r_gap_cnt == c_GAP_LAST)));

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_next = S_ACCEPT;
        S_ACCEPT: if (s_valid) w_next = S_WRITE;
        S_WRITE: begin
          if (c_HAS_GAP)        w_next = S_GAP;
          else if (w_last_cell) w_next = S_DONE;
          else                  w_next = S_ACCEPT;
        end
        S_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) w_next = w_last_cell ? S_DONE : S_ACCEPT;
        end
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr_row <= '0;
      r_addr_col <= '0;
      r_weight   <= '0;
      r_cells    <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state <= w_next;

      if (w_start_ok) begin
        r_addr_row <= '0;
        r_addr_col <= '0;
        r_cells    <= '0;
      end else if (w_decide && !w_last_cell) begin
        if (r_addr_col == c_COL_LAST) begin
          r_addr_col <= '0;
          r_addr_row <= r_addr_row + 1'b1;
        end else begin
          r_addr_col <= r_addr_col + 1'b1;
        end
      end

      if (w_hs) r_weight <= s_data;

      // Count every strobe actually issued, including one cut short by abort.
      if ((r_state == S_WRITE) && (r_cells != 16'hFFFF)) r_cells <= r_cells + 16'd1;

      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
      else                  r_gap_cnt <= '0;
    end
  end

`ifdef MLC_LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (r_state == S_WRITE) begin
      r_checksum <= r_checksum + 16'(r_weight);
    end
  end

  assign checksum = r_checksum;
`endif

  assign s_ready       = (r_state == S_ACCEPT);
  assign prog_en       = (r_state == S_WRITE);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign addr_row      = r_addr_row;
  assign addr_col      = r_addr_col;
  assign weight_val    = r_weight;
  assign cells_written = r_cells;

endmodule
`default_nettype wire

// File: doc/mlc_weight_loader.md
Name: mlc_weight_loader

Overview:
Programming sequencer that drives the weight-programming port of the MLC crossbar controller: prog_en, addr_row, addr_col and weight_val.
- Accepts a valid/ready stream of MLC weight codes.
- Writes them in row-major order across the ROWS x COLS array, one prog_en pulse per cell.
- Inserts a programmable settle gap after each write pulse to model ReRAM write recovery.
- Reports busy, done and the write count to the host or test sequencer.

Parameters:
ROWS, 32, crossbar rows (must match the target controller)
COLS, 10, crossbar columns (must match the target controller)
WEIGHT_PRECISION, 4, bits per MLC weight code
PROG_GAP, 2, idle cycles after each prog_en pulse; 0 is legal
ROW_AW, 5, addr_row width; requires 2**ROW_AW >= ROWS
COL_AW, 4, addr_col width; requires 2**COL_AW >= COLS

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a full-array load; honoured only in IDLE
abort  input  1  terminate the load and return to IDLE
s_valid  input  1  weight beat valid
s_ready  output  1  loader can accept a beat
s_data  input  WEIGHT_PRECISION  weight code
prog_en  output  1  one-cycle write strobe to the crossbar controller
addr_row  output  ROW_AW  target row
addr_col  output  COL_AW  target column
weight_val  output  WEIGHT_PRECISION  code being written
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the last cell has been written
cells_written  output  16  prog_en pulses since the last start

Behaviour:
- Clock and reset: clk is the clock; rst_n is the reset, asynchronous and active-low.
- Reset values: state=IDLE; prog_en, done, busy and s_ready = 0; addr_row, addr_col, weight_val and cells_written = 0; gap counter = 0.
- All outputs come from registers. s_ready is a decode of the registered state.
- States: IDLE, ACCEPT, WRITE, GAP, DONE.
- IDLE:
  - start=1 and abort=0: go to ACCEPT; clear addr_row, addr_col and cells_written.
  - start while not in IDLE is ignored.
- ACCEPT: s_ready=1. On s_valid&&s_ready, capture s_data into weight_val and go to WRITE. Without s_valid, stay in ACCEPT (no timeout).
- WRITE:
  - prog_en=1 for exactly one cycle; addr_row/addr_col/weight_val are stable in that cycle.
  - cells_written increments in this cycle.
  - Next state is GAP if PROG_GAP>0, otherwise the post-write decision.
- GAP: count PROG_GAP cycles with prog_en=0, then make the post-write decision.
- Post-write decision:
  - If the cell just written is (ROWS-1, COLS-1): go to DONE.
  - Otherwise advance the address and go to ACCEPT.
  - Address advance: addr_col+1; at COLS-1, addr_col wraps to 0 and addr_row increments.
- DONE: done=1 for one cycle, then IDLE. Addresses are held at their final value.
- Latency: a handshake accepted in cycle t gives prog_en=1 in cycle t+1.
- Minimum cycles per cell: 2+PROG_GAP.
- Abort:
  - From any state, the next state is IDLE and prog_en is forced 0 in the following cycle.
  - No done pulse is issued. cells_written holds its value.
  - Abort takes priority over start and over a same-cycle handshake; that beat is not consumed.
- s_data is never written twice and never dropped once accepted.
- cells_written saturates at 16'hFFFF; this is unreachable for default sizes.
- Reset mid-load: immediate return to reset values; the crossbar is left partially programmed, and the host must reload.

Optional Feature:
MLC_LOADER_CHECKSUM_EN
- Defined:
  - Adds output port checksum [15:0]: the modulo-2^16 sum of every weight_val written with prog_en=1 since the last start.
  - Cleared on an accepted start; reset value 0.
  - Holds its value on abort.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Full load, default parameters, s_valid held 1, s_data = beat index mod 16 -> 320 prog_en pulses in row-major order; last write at addr (31,9) with value 15; exactly one done pulse; cells_written=320; busy falls the cycle after done.
- Backpressure: s_valid toggled 1/0 every cycle -> prog_en only follows accepted beats; sequence 0,1,2,... written to (0,0),(0,1),(0,2)... with no gaps or duplicates; column wrap goes from (0,9) to (1,0).
- PROG_GAP=0, s_valid held 1 -> prog_en on every second cycle; 320 writes complete in 640 cycles after start plus the DONE cycle.
- Abort asserted in the cycle after the 5th prog_en -> prog_en stays 0 from the next cycle; busy=0; no done; cells_written=5; a new start writes its first beat to (0,0) and cells_written restarts at 1.
- start asserted while busy is ignored (address sequence unaffected); start and abort in the same IDLE cycle -> remains IDLE, busy=0; rst_n pulsed mid-load -> all outputs return to 0 asynchronously.
- With MLC_LOADER_CHECKSUM_EN defined, all weights 15 -> checksum=4800 at done; after abort at 10 writes of value 3 -> checksum=30.
